// File: rtl/fifo_rd_checker.sv
// FIFO read-side checker: drains a FIFO, compares each word against an incrementing
// expected value and records the count of words, the count of mismatches and the first mismatch.
module fifo_rd_checker #(
    parameter int unsigned   DW          = 8,
    parameter int unsigned   CW          = 16,
    parameter logic [DW-1:0] SEED        = '0,
    parameter bit            STOP_ON_ERR = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          clr,
    input  logic          empty,
    output logic          rd_en,
    input  logic [DW-1:0] dout,
    output logic [CW-1:0] rx_count,
    output logic [7:0]    err_count,
    output logic          err,
    output logic [DW-1:0] err_exp,
    output logic [DW-1:0] err_got,
    output logic          busy
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StHalt} state_e;

    localparam logic [CW-1:0] RxOne  = CW'(1);
    localparam logic [DW-1:0] DwOne  = DW'(1);
    localparam logic [7:0]    ErrMax = 8'hFF;

    state_e        state_q, state_d;
    logic          rd_valid_q;
    logic [DW-1:0] exp_q;
    logic [CW-1:0] rx_count_q;
    logic [7:0]    err_count_q;
    logic          err_q;
    logic [DW-1:0] err_exp_q, err_got_q;

    logic mismatch;
    logic halt_now;

    assign mismatch = rd_valid_q && (dout != exp_q);
    // Stop reading in the same cycle the mismatch is seen so no further word is popped.
    assign halt_now = STOP_ON_ERR && (state_q == StRun) && mismatch;

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        case (state_q)
            StIdle: begin
                if (enable) state_d = StRun;
            end
            StRun: begin
                if (halt_now) begin
                    state_d = StHalt;
                end else begin
                    rd_en = enable & ~empty;
                    if (!enable) state_d = StDrain;
                end
            end
            StDrain: begin
                if (!rd_valid_q) state_d = StIdle;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (clr) begin
            state_d = StIdle;
            rd_en   = 1'b0;
        end
        if (!rst_n) rd_en = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rd_valid_q  <= 1'b0;
            exp_q       <= SEED;
            rx_count_q  <= '0;
            err_count_q <= '0;
            err_q       <= 1'b0;
            err_exp_q   <= '0;
            err_got_q   <= '0;
        end else if (clr) begin
            state_q     <= StIdle;
            rd_valid_q  <= 1'b0;
            exp_q       <= SEED;
            rx_count_q  <= '0;
            err_count_q <= '0;
            err_q       <= 1'b0;
            err_exp_q   <= '0;
            err_got_q   <= '0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= rd_en;
            if (rd_valid_q) begin
                rx_count_q <= rx_count_q + RxOne;
                if (mismatch) begin
                    exp_q <= dout + DwOne;
                    if (err_count_q != ErrMax) err_count_q <= err_count_q + 8'd1;
                    err_q <= 1'b1;
                    if (!err_q) begin
                        err_exp_q <= exp_q;
                        err_got_q <= dout;
                    end
                end else begin
                    exp_q <= exp_q + DwOne;
                end
            end
        end
    end

    assign rx_count  = rx_count_q;
    assign err_count = err_count_q;
    assign err       = err_q;
    assign err_exp   = err_exp_q;
    assign err_got   = err_got_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Directed bench for fifo_rd_checker: two instances (free-running and stop-on-error),
// each fed by a simple array-based FIFO model.
module tb_fifo_rd_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    // Instance 1: STOP_ON_ERR = 0
    logic        enable1 = 1'b0, clr1 = 1'b0, empty1, rd_en1, err1, busy1;
    logic [7:0]  dout1 = 8'h00, err_count1, err_exp1, err_got1;
    logic [15:0] rx_count1;

    // Instance 2: STOP_ON_ERR = 1
    logic        enable2 = 1'b0, clr2 = 1'b0, empty2, rd_en2, err2, busy2;
    logic [7:0]  dout2 = 8'h00, err_count2, err_exp2, err_got2;
    logic [15:0] rx_count2;

    fifo_rd_checker #(.DW(8), .CW(16), .SEED(8'h00), .STOP_ON_ERR(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable1), .clr(clr1), .empty(empty1),
        .rd_en(rd_en1), .dout(dout1), .rx_count(rx_count1), .err_count(err_count1),
        .err(err1), .err_exp(err_exp1), .err_got(err_got1), .busy(busy1)
    );

    fifo_rd_checker #(.DW(8), .CW(16), .SEED(8'h00), .STOP_ON_ERR(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable2), .clr(clr2), .empty(empty2),
        .rd_en(rd_en2), .dout(dout2), .rx_count(rx_count2), .err_count(err_count2),
        .err(err2), .err_exp(err_exp2), .err_got(err_got2), .busy(busy2)
    );

    // FIFO models: data appears on dout the cycle after rd_en is sampled.
    logic [7:0] mem1 [0:1023];
    logic [7:0] mem2 [0:15];
    int wp1 = 0, rp1 = 0, wp2 = 0, rp2 = 0;
    int pulses1 = 0;

    assign empty1 = (rp1 == wp1);
    assign empty2 = (rp2 == wp2);

    always @(posedge clk) begin
        if (rd_en1) begin
            dout1   <= mem1[rp1[9:0]];
            rp1     <= rp1 + 1;
            pulses1 <= pulses1 + 1;
        end
        if (rd_en2) begin
            dout2 <= mem2[rp2[3:0]];
            rp2   <= rp2 + 1;
        end
    end

    task automatic push1(input logic [7:0] v);
        mem1[wp1[9:0]] = v;
        wp1 = wp1 + 1;
    endtask

    task automatic push2(input logic [7:0] v);
        mem2[wp2[3:0]] = v;
        wp2 = wp2 + 1;
    endtask

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    task automatic clr1_pulse();
        clr1 = 1'b1;
        @(negedge clk);
        clr1 = 1'b0;
    endtask

    initial begin
        int p0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_rx", 32'(rx_count1), 0);
        check_eq("rst_errcnt", 32'(err_count1), 0);
        check_eq("rst_err", 32'(err1), 0);
        check_eq("rst_busy", 32'(busy1), 0);
        check_eq("rst_rd_en", 32'(rd_en1), 0);
        rst_n = 1'b1;

        // Preloaded 0..9, exactly 10 reads
        p0 = pulses1;
        for (int i = 0; i < 10; i++) push1(8'(i));
        enable1 = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("a_pulses", 32'(pulses1 - p0), 10);
        check_eq("a_rx", 32'(rx_count1), 10);
        check_eq("a_err", 32'(err1), 0);
        check_eq("a_rd_en_empty", 32'(rd_en1), 0);
        check_eq("a_empty", 32'(empty1), 1);

        // 300-word stream with expected-value wrap
        clr1_pulse();
        check_eq("clr_rx", 32'(rx_count1), 0);
        for (int i = 0; i < 300; i++) push1(8'(i));
        repeat (320) @(negedge clk);
        check_eq("b_rx", 32'(rx_count1), 300);
        check_eq("b_err", 32'(err1), 0);
        check_eq("b_errcnt", 32'(err_count1), 0);

        // Stream 0,1,2,7,8,3: two mismatches, first is exp 3 / got 7
        clr1_pulse();
        push1(8'h00); push1(8'h01); push1(8'h02);
        push1(8'h07); push1(8'h08); push1(8'h03);
        repeat (15) @(negedge clk);
        check_eq("c_errcnt", 32'(err_count1), 2);
        check_eq("c_err", 32'(err1), 1);
        check_eq("c_err_exp", 32'(err_exp1), 32'h03);
        check_eq("c_err_got", 32'(err_got1), 32'h07);
        check_eq("c_rx", 32'(rx_count1), 6);

        // Enable dropped the cycle after rd_en: pending word checked, DRAIN, IDLE
        enable1 = 1'b0;
        clr1_pulse();
        @(negedge clk);
        push1(8'h00);
        enable1 = 1'b1;
        @(negedge clk);
        check_eq("d_rd_en", 32'(rd_en1), 1);
        @(posedge clk);
        #1 enable1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("d_drain_busy", 32'(busy1), 1);
        check_eq("d_rx", 32'(rx_count1), 1);
        @(negedge clk);
        check_eq("d_idle_busy", 32'(busy1), 0);
        check_eq("d_err", 32'(err1), 0);

        // Reset for one edge with a word pending
        clr1_pulse();
        push1(8'h00); push1(8'h01);
        enable1 = 1'b1;
        for (int i = 0; i < 10 && !rd_en1; i++) @(negedge clk);
        check_eq("e_rd_en_seen", 32'(rd_en1), 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_eq("e_rd_en_in_rst", 32'(rd_en1), 0);
        @(posedge clk);
        #1 begin
            rst_n   = 1'b1;
            enable1 = 1'b0;
        end
        @(negedge clk);
        check_eq("e_rx", 32'(rx_count1), 0);
        check_eq("e_err", 32'(err1), 0);
        check_eq("e_rd_en", 32'(rd_en1), 0);
        check_eq("e_busy", 32'(busy1), 0);

        // STOP_ON_ERR: stream 0,1,5,6 halts after word 5
        push2(8'h00); push2(8'h01); push2(8'h05); push2(8'h06);
        enable2 = 1'b1;
        repeat (15) @(negedge clk);
        check_eq("f_busy_halt", 32'(busy2), 1);
        check_eq("f_rd_en", 32'(rd_en2), 0);
        check_eq("f_empty", 32'(empty2), 0);
        check_eq("f_rx", 32'(rx_count2), 3);
        check_eq("f_errcnt", 32'(err_count2), 1);
        check_eq("f_err_exp", 32'(err_exp2), 32'h02);
        check_eq("f_err_got", 32'(err_got2), 32'h05);
        enable2 = 1'b0;
        clr2    = 1'b1;
        @(negedge clk);
        clr2 = 1'b0;
        @(negedge clk);
        check_eq("g_busy", 32'(busy2), 0);
        check_eq("g_rx", 32'(rx_count2), 0);
        check_eq("g_errcnt", 32'(err_count2), 0);
        check_eq("g_err", 32'(err2), 0);
        check_eq("g_err_exp", 32'(err_exp2), 0);
        check_eq("g_err_got", 32'(err_got2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_rd_checker.md
FIFO_RD_CHECKER -- requirements
Module: fifo_rd_checker

Interface
REQ-001 The block SHALL have parameter DW, default 8, data width of the FIFO read port.
REQ-002 The block SHALL have parameter CW, default 16, width of the received-word counter.
REQ-003 The block SHALL have parameter SEED, default 0, first expected data value after reset or clear.
REQ-004 The block SHALL have parameter STOP_ON_ERR, default 0; when 1, the first mismatch halts reading.
REQ-005 The block SHALL have clk, input, 1, the single clock for all state.
REQ-006 The block SHALL have rst_n, input, 1, reset that is synchronous and active-low.
REQ-007 The block SHALL have enable, input, 1, which permits reading while high.
REQ-008 The block SHALL have clr, input, 1, a synchronous clear pulse for counters, errors and the expected value.
REQ-009 The block SHALL have empty, input, 1, the FIFO empty flag.
REQ-010 The block SHALL have rd_en, output, 1, the FIFO read strobe.
REQ-011 The block SHALL have dout, input, DW, FIFO read data, valid the cycle after rd_en is sampled high.
REQ-012 The block SHALL have rx_count, output, CW, the number of words checked.
REQ-013 The block SHALL have err_count, output, 8, the number of mismatches.
REQ-014 The block SHALL have err, output, 1, a sticky mismatch flag.
REQ-015 The block SHALL have err_exp and err_got, output, DW each, the expected and received values of the first mismatch.
REQ-016 The block SHALL have busy, output, 1, high when the state is not IDLE.

Function
REQ-017 The block SHALL implement an FSM with states IDLE, RUN, DRAIN and HALT.
REQ-018 IDLE SHALL move to RUN on enable=1; rd_en=0 in IDLE.
REQ-019 In RUN, rd_en SHALL be the combinational value enable & ~empty; there is no rd_en when empty=1.
REQ-020 RUN SHALL move to DRAIN when enable=0.
REQ-021 DRAIN SHALL hold rd_en=0, complete any pending valid word, then move to IDLE on the next edge with no word pending.
REQ-022 A registered rd_valid SHALL set on each edge sampling rd_en=1, so dout is checked exactly one cycle after the read.
REQ-023 The block SHALL process each valid word on the edge closing its cycle.
REQ-024 Each valid word SHALL increment rx_count by 1, wrapping modulo 2^CW.
REQ-025 On a match (dout == exp), exp SHALL become exp+1, wrapping modulo 2^DW (e.g. 0xFF -> 0x00).
REQ-026 On a mismatch, exp SHALL be resynchronised to dout+1.
REQ-027 On a mismatch, err_count SHALL increment, saturating at 255.
REQ-028 On a mismatch, err SHALL be set to 1.
REQ-029 err_exp and err_got SHALL be captured only when err was 0, i.e. first mismatch only.
REQ-030 With STOP_ON_ERR=1, a mismatch in RUN SHALL move to HALT, with rd_en deasserted from that cycle on.
REQ-031 HALT SHALL be left only by clr or reset; a word already pending on entry SHALL still be counted and checked.
REQ-032 clr=1 SHALL zero rx_count, err_count, err, err_exp and err_got, set exp=SEED, drop any pending word uncounted and go to IDLE.
REQ-033 clr SHALL win over a simultaneous valid word and over enable.
REQ-034 An empty that rises while a word is pending SHALL NOT affect the check of that word.

Reset
REQ-035 When rst_n=0 at an edge, the block SHALL enter state IDLE with rd_valid=0, exp=SEED, rx_count=0, err_count=0, err=0, err_exp=0, err_got=0 and busy=0.
REQ-036 During reset rd_en SHALL be 0.
REQ-037 Reset asserted mid-read SHALL discard the pending word, which is not counted.

Verification
REQ-038 A bench SHALL cover: SEED=0, FIFO preloaded 0x00..0x09, enable=1 -> exactly 10 rd_en pulses, rx_count=10, err=0, then rd_en=0 while empty=1.
REQ-039 A bench SHALL cover: an incrementing stream of 300 words -> exp wraps 0xFF->0x00 with no error, rx_count=300.
REQ-040 A bench SHALL cover: stream 0,1,2,7,8,3 -> err_count=2, err=1, err_exp=0x03, err_got=0x07, rx_count=6.
REQ-041 A bench SHALL cover: STOP_ON_ERR=1, stream 0,1,5,6 -> HALT after word 5, rd_en=0 afterwards, rx_count=3; clr -> IDLE with all counters 0.
REQ-042 A bench SHALL cover: enable dropped the cycle after rd_en -> the pending word is still checked, DRAIN then IDLE, busy=0.
REQ-043 A bench SHALL cover: rst_n=0 for one edge with a word pending -> rx_count=0, err=0, rd_en=0, state IDLE.
